svc_rv_mdu_iter: RTL and testbench
==================================

// Module: svc_rv_mdu_iter
//
// PURPOSE
// - Iterative RV32M/RV64M multiply/divide unit for the pipelined svc_rv core
//   with EXT_M enabled; sits beside the EX-stage ALU.
// - Takes a funct3-encoded M op, retires R bits per cycle, returns one result
//   with a destination tag; EX stalls on op_ready/res_valid.
// - Generalises the fixed 32-bit M path in XLEN, bits/cycle and tag width,
//   and adds kill/abort.
//
// PARAMETERS
// - XLEN      32  operand/result width; 32 or 64
// - R         1   bits retired per CALC cycle; 1, 2 or 4; must divide XLEN
// - TAG_W     5   width of the tag passed through (rd index)
//
// PORTS
// - clk        in   1      clock
// - rst        in   1      synchronous reset, active high
// - op_valid   in   1      op request
// - op_ready   out  1      unit idle, can accept
// - op_funct3  in   3      0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
// - op_a       in   XLEN   rs1 value
// - op_b       in   XLEN   rs2 value
// - op_tag     in   TAG_W  tag, returned unchanged
// - kill       in   1      abort the in-flight op (pipeline flush)
// - res_valid  out  1      result available
// - res_ready  in   1      consumer takes result
// - res_data   out  XLEN   result
// - res_tag    out  TAG_W  tag of result
//
// BEHAVIOUR
// - Reset: state IDLE, op_ready=1, res_valid=0, res_data=0, res_tag=0, count=0.
// - Accept on op_valid && op_ready. Latch funct3, tag, |a|, |b| and result
//   sign. Signed ops are MULH, DIV, REM; MULHSU treats only a as signed.
// - FSM: IDLE -> CALC (N=XLEN/R cycles) -> FIXUP (1 cycle) -> DONE.
//   DONE -> IDLE on res_ready.
//   - op_ready=1 only in IDLE; res_valid=1 only in DONE.
//   - res_data/res_tag hold stable while res_valid && !res_ready.
// - Latency: res_valid rises N+2 edges after the accepting edge.
//   XLEN=32: R=1 gives 34, R=2 gives 18, R=4 gives 10.
//   - Back-to-back: a new op can be accepted the cycle after the res handshake.
// - MUL: shift-add on magnitudes; R partial products per cycle into a
//   2*XLEN accumulator. FIXUP negates the accumulator if the sign is set, then
//   selects the low half (MUL) or high half (MULH*).
// - DIV/REM: restoring division on magnitudes, R quotient bits per cycle.
//   FIXUP negates the quotient if the operand signs differ, and negates the
//   remainder to take the dividend's sign.
// - Divide by zero (b=0): quotient = all ones, remainder = a, for signed and
//   unsigned. No trap.
// - Signed overflow (a = -2^(XLEN-1), b = -1): DIV gives a, REM gives 0.
// - Width rule: all intermediates are exactly XLEN or 2*XLEN bits; no
//   truncation before FIXUP.
// - kill: in CALC/FIXUP/DONE, state goes to IDLE next edge and res_valid is
//   forced 0. kill in IDLE is ignored, and an op_valid in that same cycle is
//   not accepted.
// - kill && res_ready together in DONE: treated as kill.
// - Reset mid-operation: same as the reset state; no result is emitted.
// - Illegal R (not 1/2/4, or not dividing XLEN): elaboration $fatal.
//
// CONFIGURATION
// - SVC_RV_MDU_EARLY_OUT_EN
//   - Defined: at accept, DIV*/REM* with b=0 or signed overflow, and any MUL*
//     with a=0 or b=0, skip CALC and FIXUP.
//     - Result is computed combinationally at accept and sent straight to DONE.
//     - res_valid rises 1 edge after accept.
//   - Undefined: every op takes the full N+2 cycles. Special-case results are
//     still as specified, produced in FIXUP.
//
// TESTING
// - XLEN=32, R=1: MUL 7*-3 -> 0xFFFFFFEB at cycle 34.
//   MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
// - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14;
//   REMU 100/7 -> 2.
// - DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
//   DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5. Early-out: latency 1, else 34.
// - kill at CALC cycle 10 of DIV -> op_ready=1 next cycle, no res_valid.
//   Next op MUL 3*4 returns 12 with its own tag.
// - Hold res_ready=0 for 5 cycles in DONE -> res_data/res_tag stable,
//   op_ready=0. Then res_ready=1 -> IDLE.
// - XLEN=64, R=4: MULH -1*-1 -> 0, MULHSU -1*2 -> all ones, latency 18.
//   Random 1000 ops vs. reference model, all eight funct3 codes.

Source files
------------

// File: rtl/svc_rv_mdu_iter.sv
// rtl/svc_rv_mdu_iter.sv - iterative RV32M/RV64M multiply/divide unit retiring R bits per cycle
// Optional feature macro: SVC_RV_MDU_EARLY_OUT_EN (trivial ops resolved at accept).
module svc_rv_mdu_iter #(
    parameter int XLEN  = 32,
    parameter int R     = 1,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_funct3,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    input  logic [TAG_W-1:0] op_tag,
    input  logic             kill,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [XLEN-1:0]  res_data,
    output logic [TAG_W-1:0] res_tag
);
    localparam int N  = XLEN / R;
    localparam int CW = $clog2(N + 1);

    if (!(R == 1 || R == 2 || R == 4) || (XLEN % R) != 0 || !(XLEN == 32 || XLEN == 64)) begin : g_bad_cfg
        $fatal(1, "svc_rv_mdu_iter: illegal XLEN/R combination");
    end

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     count;
    logic [2:0]        funct3_q;
    logic [TAG_W-1:0]  tag_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] acc;
    logic              sign_q;
    logic              sign_a_q;
    logic              b_zero_q;

    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;

    always_comb begin
        a_signed = (op_funct3 == 3'd1) || (op_funct3 == 3'd2) || (op_funct3 == 3'd4) || (op_funct3 == 3'd6);
        b_signed = (op_funct3 == 3'd1) || (op_funct3 == 3'd4) || (op_funct3 == 3'd6);
        a_neg    = a_signed && op_a[XLEN-1];
        b_neg    = b_signed && op_b[XLEN-1];
        a_mag    = a_neg ? -op_a : op_a;
        b_mag    = b_neg ? -op_b : op_b;
    end

    // acc holds {hi, lo}: product being shifted right, or {remainder, dividend/quotient} shifted left.
    logic [2*XLEN-1:0] step;
    logic [XLEN:0]     trial;
    logic [XLEN:0]     sum;
    logic              ge;

    always_comb begin
        step  = acc;
        trial = '0;
        sum   = '0;
        ge    = 1'b0;
        for (int i = 0; i < R; i++) begin
            if (funct3_q[2]) begin
                trial = step[2*XLEN-1:XLEN-1];
                ge    = trial >= {1'b0, opnd_q};
                step  = {(ge ? (trial[XLEN-1:0] - opnd_q) : trial[XLEN-1:0]), step[XLEN-2:0], ge};
            end else begin
                sum  = {1'b0, step[2*XLEN-1:XLEN]} + (step[0] ? {1'b0, opnd_q} : '0);
                step = {sum, step[XLEN-1:1]};
            end
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fix_res;

    always_comb begin
        prod = sign_q ? -acc : acc;
        quo  = b_zero_q ? '1 : (sign_q ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
        rem  = sign_a_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (!funct3_q[2]) begin
            fix_res = (funct3_q[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end else begin
            fix_res = funct3_q[1] ? rem : quo;
        end
    end

`ifdef SVC_RV_MDU_EARLY_OUT_EN
    logic            eo_hit;
    logic            eo_ovf;
    logic [XLEN-1:0] eo_res;

    always_comb begin
        eo_ovf = op_funct3[2] && !op_funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b);
        eo_hit = 1'b0;
        eo_res = '0;
        if (!op_funct3[2]) begin
            eo_hit = (op_a == '0) || (op_b == '0);
        end else if (op_b == '0) begin
            eo_hit = 1'b1;
            eo_res = op_funct3[1] ? op_a : '1;
        end else if (eo_ovf) begin
            eo_hit = 1'b1;
            eo_res = op_funct3[1] ? '0 : op_a;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_ready  <= 1'b1;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_tag   <= '0;
            count     <= '0;
            funct3_q  <= '0;
            tag_q     <= '0;
            opnd_q    <= '0;
            acc       <= '0;
            sign_q    <= 1'b0;
            sign_a_q  <= 1'b0;
            b_zero_q  <= 1'b0;
        end else if (kill && state != IDLE) begin
            state     <= IDLE;
            op_ready  <= 1'b1;
            res_valid <= 1'b0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid && !kill) begin
                        funct3_q <= op_funct3;
                        tag_q    <= op_tag;
                        opnd_q   <= op_funct3[2] ? b_mag : a_mag;
                        acc      <= {{XLEN{1'b0}}, (op_funct3[2] ? a_mag : b_mag)};
                        sign_q   <= a_neg ^ b_neg;
                        sign_a_q <= a_neg;
                        b_zero_q <= (op_b == '0);
                        op_ready <= 1'b0;
                        count    <= '0;
`ifdef SVC_RV_MDU_EARLY_OUT_EN
                        if (eo_hit) begin
                            state     <= DONE;
                            res_valid <= 1'b1;
                            res_data  <= eo_res;
                            res_tag   <= op_tag;
                        end else begin
                            state <= CALC;
                        end
`else
                        state    <= CALC;
`endif
                    end
                end
                CALC: begin
                    acc   <= step;
                    count <= count + 1'b1;
                    if (count == CW'(N - 1)) begin
                        count <= '0;
                        state <= FIXUP;
                    end
                end
                FIXUP: begin
                    res_data  <= fix_res;
                    res_tag   <= tag_q;
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_svc_rv_mdu_iter.sv
// tb/tb_svc_rv_mdu_iter.sv - scoreboard bench for svc_rv_mdu_iter at XLEN=32/R=1 and XLEN=64/R=4
module tb_svc_rv_mdu_iter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        op_valid32, op_ready32, kill32, res_valid32, res_ready32;
    logic [2:0]  f3_32;
    logic [31:0] a32, b32, res_data32;
    logic [4:0]  tag32, res_tag32;
    logic        op_valid64, op_ready64, kill64, res_valid64, res_ready64;
    logic [2:0]  f3_64;
    logic [63:0] a64, b64, res_data64;
    logic [4:0]  tag64, res_tag64;

    svc_rv_mdu_iter #(.XLEN(32), .R(1), .TAG_W(5)) dut32 (
        .clk(clk), .rst(rst), .op_valid(op_valid32), .op_ready(op_ready32), .op_funct3(f3_32),
        .op_a(a32), .op_b(b32), .op_tag(tag32), .kill(kill32), .res_valid(res_valid32),
        .res_ready(res_ready32), .res_data(res_data32), .res_tag(res_tag32));

    svc_rv_mdu_iter #(.XLEN(64), .R(4), .TAG_W(5)) dut64 (
        .clk(clk), .rst(rst), .op_valid(op_valid64), .op_ready(op_ready64), .op_funct3(f3_64),
        .op_a(a64), .op_b(b64), .op_tag(tag64), .kill(kill64), .res_valid(res_valid64),
        .res_ready(res_ready64), .res_data(res_data64), .res_tag(res_tag64));

`ifdef SVC_RV_MDU_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif

    typedef struct { logic [63:0] data; logic [4:0] tag; int lat; } exp_t;
    typedef struct { bit w; logic [2:0] f3; logic [63:0] a; logic [63:0] b; logic [63:0] d; } vec_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [63:0] obs_d;
    logic [4:0]  obs_t;
    int          obs_lat;

    function automatic logic [63:0] model(input int xl, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
        logic signed [129:0] av, bv, r, one;
        logic [63:0] m;
        bit sa, sbb;
        one = 1;
        m   = (xl == 64) ? {64{1'b1}} : 64'hFFFF_FFFF;
        sa  = (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd6);
        sbb = (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd6);
        av  = $signed({66'b0, a & m});
        bv  = $signed({66'b0, b & m});
        if (sa && a[xl-1]) av = av - (one << xl);
        if (sbb && b[xl-1]) bv = bv - (one << xl);
        case (f3)
            3'd0:             r = av * bv;
            3'd1, 3'd2, 3'd3: r = (av * bv) >>> xl;
            3'd4, 3'd5:       r = (bv == 0) ? -one : av / bv;
            default:          r = (bv == 0) ? av : av % bv;
        endcase
        return r[63:0] & m;
    endfunction

    function automatic bit early(input int xl, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] mn, ones;
        bit hit;
        mn   = (xl == 64) ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
        ones = (xl == 64) ? {64{1'b1}} : 64'hFFFF_FFFF;
        if (!f3[2]) hit = (a == 0) || (b == 0);
        else        hit = (b == 0) || (!f3[0] && a == mn && b == ones);
        return EO && hit;
    endfunction

    // Drives one op from posedge+1, pushes its expectation, waits (bounded) and takes the result.
    task automatic issue(input bit w, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] tag, input logic [63:0] exp_d);
        exp_t e;
        e.data = exp_d;
        e.tag  = tag;
        e.lat  = early(w ? 64 : 32, f3, a, b) ? 1 : (w ? 18 : 34);
        sb.push_back(e);
        if (w) begin op_valid64 = 1; f3_64 = f3; a64 = a; b64 = b; tag64 = tag; end
        else   begin op_valid32 = 1; f3_32 = f3; a32 = a[31:0]; b32 = b[31:0]; tag32 = tag; end
        @(posedge clk); #1;
        op_valid32 = 0;
        op_valid64 = 0;
        obs_lat = 1;
        while (!(w ? res_valid64 : res_valid32) && obs_lat < 100) begin
            @(posedge clk); #1;
            obs_lat++;
        end
        if (!(w ? res_valid64 : res_valid32)) obs_lat = -1;
        obs_d = w ? res_data64 : {32'b0, res_data32};
        obs_t = w ? res_tag64 : res_tag32;
        res_ready32 = !w;
        res_ready64 = w;
        @(posedge clk); #1;
        res_ready32 = 0;
        res_ready64 = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        op_valid32 = 0; kill32 = 0; res_ready32 = 0; f3_32 = 0; a32 = 0; b32 = 0; tag32 = 0;
        op_valid64 = 0; kill64 = 0; res_ready64 = 0; f3_64 = 0; a64 = 0; b64 = 0; tag64 = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        n_tests++; if (op_ready32 !== 1'b1) begin n_fail++; $display("FAIL reset op_ready32: got %b want 1", op_ready32); end
        n_tests++; if (res_valid32 !== 1'b0) begin n_fail++; $display("FAIL reset res_valid32: got %b want 0", res_valid32); end
        n_tests++; if (res_data32 !== 32'h0) begin n_fail++; $display("FAIL reset res_data32: got %h want 0", res_data32); end
        n_tests++; if (res_tag32 !== 5'h0) begin n_fail++; $display("FAIL reset res_tag32: got %h want 0", res_tag32); end
        n_tests++; if (op_ready64 !== 1'b1) begin n_fail++; $display("FAIL reset op_ready64: got %b want 1", op_ready64); end
        n_tests++; if (res_valid64 !== 1'b0) begin n_fail++; $display("FAIL reset res_valid64: got %b want 0", res_valid64); end
        n_tests++; if (res_data64 !== 64'h0) begin n_fail++; $display("FAIL reset res_data64: got %h want 0", res_data64); end
    endtask

    task automatic test_mul();
        vec_t v [10];
        exp_t e;
        v = '{'{1'b0, 3'd0, 64'd7,          64'hFFFF_FFFD, 64'hFFFF_FFEB},
              '{1'b0, 3'd3, 64'hFFFF_FFFF,  64'hFFFF_FFFF, 64'hFFFF_FFFE},
              '{1'b0, 3'd0, 64'd3,          64'd4,         64'd12},
              '{1'b0, 3'd1, 64'h8000_0000,  64'h8000_0000, 64'h4000_0000},
              '{1'b0, 3'd2, 64'hFFFF_FFFF,  64'hFFFF_FFFF, 64'hFFFF_FFFF},
              '{1'b0, 3'd1, 64'hFFFF_FFFF,  64'hFFFF_FFFF, 64'h0},
              '{1'b0, 3'd0, 64'd0,          64'd5,         64'h0},
              '{1'b1, 3'd1, {64{1'b1}},     {64{1'b1}},    64'h0},
              '{1'b1, 3'd2, {64{1'b1}},     64'd2,         {64{1'b1}}},
              '{1'b1, 3'd3, {64{1'b1}},     {64{1'b1}},    64'hFFFF_FFFF_FFFF_FFFE}};
        for (int i = 0; i < 10; i++) begin
            issue(v[i].w, v[i].f3, v[i].a, v[i].b, 5'(i + 1), v[i].d);
            e = sb.pop_front();
            n_tests++; if (obs_d !== e.data) begin n_fail++; $display("FAIL mul[%0d] data: got %h want %h", i, obs_d, e.data); end
            n_tests++; if (obs_t !== e.tag) begin n_fail++; $display("FAIL mul[%0d] tag: got %h want %h", i, obs_t, e.tag); end
            n_tests++; if (obs_lat != e.lat) begin n_fail++; $display("FAIL mul[%0d] latency: got %0d want %0d", i, obs_lat, e.lat); end
        end
    endtask

    task automatic test_div();
        vec_t v [14];
        exp_t e;
        v = '{'{1'b0, 3'd4, 64'hFFFF_FFF9, 64'd2,         64'hFFFF_FFFD},
              '{1'b0, 3'd6, 64'hFFFF_FFF9, 64'd2,         64'hFFFF_FFFF},
              '{1'b0, 3'd5, 64'd100,       64'd7,         64'd14},
              '{1'b0, 3'd7, 64'd100,       64'd7,         64'd2},
              '{1'b0, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000},
              '{1'b0, 3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0},
              '{1'b0, 3'd5, 64'd5,         64'd0,         64'hFFFF_FFFF},
              '{1'b0, 3'd7, 64'd5,         64'd0,         64'd5},
              '{1'b0, 3'd4, 64'hFFFF_FFFB, 64'd0,         64'hFFFF_FFFF},
              '{1'b0, 3'd6, 64'hFFFF_FFFB, 64'd0,         64'hFFFF_FFFB},
              '{1'b0, 3'd6, 64'd7,         64'hFFFF_FFFE, 64'd1},
              '{1'b0, 3'd4, 64'd7,         64'hFFFF_FFFE, 64'hFFFF_FFFD},
              '{1'b1, 3'd4, 64'h8000_0000_0000_0000, {64{1'b1}}, 64'h8000_0000_0000_0000},
              '{1'b1, 3'd7, 64'h1234, 64'd0, 64'h1234}};
        for (int i = 0; i < 14; i++) begin
            issue(v[i].w, v[i].f3, v[i].a, v[i].b, 5'(i + 11), v[i].d);
            e = sb.pop_front();
            n_tests++; if (obs_d !== e.data) begin n_fail++; $display("FAIL div[%0d] data: got %h want %h", i, obs_d, e.data); end
            n_tests++; if (obs_t !== e.tag) begin n_fail++; $display("FAIL div[%0d] tag: got %h want %h", i, obs_t, e.tag); end
            n_tests++; if (obs_lat != e.lat) begin n_fail++; $display("FAIL div[%0d] latency: got %0d want %0d", i, obs_lat, e.lat); end
        end
    endtask

    task automatic test_kill();
        exp_t e;
        bit seen;
        int  wait_n;
        op_valid32 = 1; f3_32 = 3'd4; a32 = 32'd1000; b32 = 32'd7; tag32 = 5'd3;
        @(posedge clk); #1;
        op_valid32 = 0;
        repeat (9) @(posedge clk);
        #1;
        kill32 = 1;
        @(posedge clk); #1;
        kill32 = 0;
        n_tests++; if (op_ready32 !== 1'b1) begin n_fail++; $display("FAIL kill_calc op_ready: got %b want 1", op_ready32); end
        n_tests++; if (res_valid32 !== 1'b0) begin n_fail++; $display("FAIL kill_calc res_valid: got %b want 0", res_valid32); end
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (res_valid32) seen = 1; end
        n_tests++; if (seen) begin n_fail++; $display("FAIL kill_calc late result: got res_valid=1 want none"); end
        issue(1'b0, 3'd0, 64'd3, 64'd4, 5'd9, 64'd12);
        e = sb.pop_front();
        n_tests++; if (obs_d !== e.data) begin n_fail++; $display("FAIL kill_next data: got %h want %h", obs_d, e.data); end
        n_tests++; if (obs_t !== e.tag) begin n_fail++; $display("FAIL kill_next tag: got %h want %h", obs_t, e.tag); end
        op_valid32 = 1; kill32 = 1; f3_32 = 3'd0; a32 = 32'd3; b32 = 32'd4; tag32 = 5'd1;
        @(posedge clk); #1;
        op_valid32 = 0; kill32 = 0;
        n_tests++; if (op_ready32 !== 1'b1) begin n_fail++; $display("FAIL kill_idle accepted: op_ready got %b want 1", op_ready32); end
        op_valid32 = 1; f3_32 = 3'd5; a32 = 32'd9; b32 = 32'd2; tag32 = 5'd2;
        @(posedge clk); #1;
        op_valid32 = 0;
        wait_n = 0;
        while (!res_valid32 && wait_n < 100) begin @(posedge clk); #1; wait_n++; end
        n_tests++; if (res_valid32 !== 1'b1) begin n_fail++; $display("FAIL kill_done reach DONE: res_valid got %b want 1", res_valid32); end
        kill32 = 1; res_ready32 = 1;
        @(posedge clk); #1;
        kill32 = 0; res_ready32 = 0;
        n_tests++; if (op_ready32 !== 1'b1 || res_valid32 !== 1'b0) begin
            n_fail++; $display("FAIL kill_done: op_ready=%b res_valid=%b want 1/0", op_ready32, res_valid32);
        end
    endtask

    task automatic test_hold();
        exp_t e;
        int   wait_n;
        e.data = 64'd14; e.tag = 5'd21; e.lat = 0;
        sb.push_back(e);
        op_valid32 = 1; f3_32 = 3'd5; a32 = 32'd100; b32 = 32'd7; tag32 = 5'd21;
        @(posedge clk); #1;
        op_valid32 = 0;
        wait_n = 0;
        while (!res_valid32 && wait_n < 100) begin @(posedge clk); #1; wait_n++; end
        e = sb.pop_front();
        for (int c = 0; c < 5; c++) begin
            n_tests++; if ({32'b0, res_data32} !== e.data || res_tag32 !== e.tag || res_valid32 !== 1'b1) begin
                n_fail++; $display("FAIL hold[%0d]: data=%h tag=%h valid=%b want %h/%h/1", c, res_data32, res_tag32, res_valid32, e.data, e.tag);
            end
            n_tests++; if (op_ready32 !== 1'b0) begin n_fail++; $display("FAIL hold[%0d] op_ready: got %b want 0", c, op_ready32); end
            @(posedge clk); #1;
        end
        res_ready32 = 1;
        @(posedge clk); #1;
        res_ready32 = 0;
        n_tests++; if (op_ready32 !== 1'b1 || res_valid32 !== 1'b0) begin
            n_fail++; $display("FAIL hold release: op_ready=%b res_valid=%b want 1/0", op_ready32, res_valid32);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 3'd0, 64'(i + 2), 64'd5, 5'(i + 26), 64'((i + 2) * 5));
            n_tests++; if (op_ready32 !== 1'b1) begin n_fail++; $display("FAIL b2b[%0d] op_ready after handshake: got %b want 1", i, op_ready32); end
            e = sb.pop_front();
            n_tests++; if (obs_d !== e.data || obs_t !== e.tag) begin
                n_fail++; $display("FAIL b2b[%0d]: data=%h tag=%h want %h/%h", i, obs_d, obs_t, e.data, e.tag);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        op_valid64 = 1; f3_64 = 3'd1; a64 = 64'd12345; b64 = 64'd678; tag64 = 5'd7;
        @(posedge clk); #1;
        op_valid64 = 0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        n_tests++; if (op_ready64 !== 1'b1 || res_valid64 !== 1'b0 || res_data64 !== 64'h0) begin
            n_fail++; $display("FAIL reset_mid: op_ready=%b res_valid=%b data=%h want 1/0/0", op_ready64, res_valid64, res_data64);
        end
        seen = 0;
        repeat (25) begin @(posedge clk); #1; if (res_valid64) seen = 1; end
        n_tests++; if (seen) begin n_fail++; $display("FAIL reset_mid late result: got res_valid=1 want none"); end
    endtask

    task automatic test_random(input bit w, input int n);
        exp_t        e;
        logic [2:0]  f3;
        logic [63:0] a, b, m, mn;
        int          xl;
        xl = w ? 64 : 32;
        m  = w ? {64{1'b1}} : 64'hFFFF_FFFF;
        mn = w ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
        for (int i = 0; i < n; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = {$urandom, $urandom} & m;
            b  = {$urandom, $urandom} & m;
            case ($urandom_range(0, 9))
                0: b = 0;
                1: begin a = mn; b = m; end
                2: a = 0;
                3: begin a = 64'($urandom_range(0, 20)); b = 64'($urandom_range(0, 5)); end
                4: b = m;
                default: ;
            endcase
            issue(w, f3, a, b, 5'($urandom_range(0, 31)), model(xl, f3, a, b));
            e = sb.pop_front();
            n_tests++; if (obs_d !== e.data) begin
                n_fail++; $display("FAIL rand%0d[%0d] f3=%0d a=%h b=%h data: got %h want %h", xl, i, f3, a, b, obs_d, e.data);
            end
            n_tests++; if (obs_t !== e.tag) begin n_fail++; $display("FAIL rand%0d[%0d] tag: got %h want %h", xl, i, obs_t, e.tag); end
            n_tests++; if (obs_lat != e.lat) begin n_fail++; $display("FAIL rand%0d[%0d] latency: got %0d want %0d", xl, i, obs_lat, e.lat); end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_kill();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_random(1'b0, 150);
        test_random(1'b1, 1000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
